// File: rtl/latch_bank.sv
// Multi-channel double-buffered register bank: per-channel loads land in a shadow
// stage and a global COMMIT moves every pending channel to Q on one edge.

module latch_bank_lane #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             mode,
  input  logic             commit,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             pend,
  output logic             pend_nxt
);

  logic [WIDTH-1:0] shadow, shadow_nxt, q_nxt;

  // A load goes straight to Q in direct mode or when it coincides with a commit.
  always_comb begin
    shadow_nxt = shadow;
    q_nxt      = q;
    pend_nxt   = pend;
    if (en) begin
      shadow_nxt = d;
      if (!mode || commit) begin
        q_nxt    = d;
        pend_nxt = 1'b0;
      end else begin
        pend_nxt = 1'b1;
      end
    end else if (commit && pend) begin
      q_nxt    = shadow;
      pend_nxt = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      shadow <= RST_VAL;
      q      <= RST_VAL;
      pend   <= 1'b0;
    end else begin
      shadow <= shadow_nxt;
      q      <= q_nxt;
      pend   <= pend_nxt;
    end
  end

endmodule

module latch_bank #(
  parameter int               CHANNELS = 4,
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          MODE,
  input  logic [CHANNELS-1:0]           EN,
  input  logic [CHANNELS*WIDTH-1:0]     D,
  input  logic                          COMMIT,
  output logic [CHANNELS*WIDTH-1:0]     Q,
  output logic [CHANNELS-1:0]           PEND,
  output logic [$clog2(CHANNELS+1)-1:0] NPEND
);

  localparam int NW = $clog2(CHANNELS+1);

  logic [CHANNELS-1:0][WIDTH-1:0] d_lane, q_lane;
  logic [CHANNELS-1:0]            pend_nxt;
  logic [NW-1:0]                  cnt_nxt;

  assign d_lane = D;
  assign Q      = q_lane;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    latch_bank_lane #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL)
    ) u_lane (
      .CLK      (CLK),
      .RST      (RST),
      .mode     (MODE),
      .commit   (COMMIT),
      .en       (EN[c]),
      .d        (d_lane[c]),
      .q        (q_lane[c]),
      .pend     (PEND[c]),
      .pend_nxt (pend_nxt[c])
    );
  end

  // Count from next-state pend bits so NPEND lands on the same edge as PEND.
  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < CHANNELS; i++)
      cnt_nxt = cnt_nxt + NW'(pend_nxt[i]);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) NPEND <= '0;
    else     NPEND <= cnt_nxt;
  end

endmodule

// File: tb/tb_latch_bank.sv
// Directed bench for latch_bank with CHANNELS=4, WIDTH=8, RST_VAL=0.

module tb_latch_bank;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        MODE = 1'b0;
  logic [3:0]  EN = '0;
  logic [31:0] D = '0;
  logic        COMMIT = 1'b0;
  logic [31:0] Q;
  logic [3:0]  PEND;
  logic [2:0]  NPEND;

  int errors = 0;
  int checks = 0;

  latch_bank #(.CHANNELS(4), .WIDTH(8), .RST_VAL(8'h00)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .MODE   (MODE),
    .EN     (EN),
    .D      (D),
    .COMMIT (COMMIT),
    .Q      (Q),
    .PEND   (PEND),
    .NPEND  (NPEND)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // 1: asynchronous reset mid-cycle, then held against active loads
    #2 RST = 1'b1;
    #1;
    check("rst_q",     Q,     32'h0);
    check("rst_pend",  {28'h0, PEND}, 32'h0);
    check("rst_npend", {29'h0, NPEND}, 32'h0);
    EN = 4'hF; D = 32'hFFFF_FFFF;
    step();
    step();
    check("rst_hold_q",    Q, 32'h0);
    check("rst_hold_pend", {28'h0, PEND}, 32'h0);
    @(negedge CLK);
    RST = 1'b0; EN = '0; D = '0;

    // 2: direct mode
    @(negedge CLK);
    MODE = 1'b0; EN = 4'b0101; D = 32'h4433_2211;
    step();
    check("direct_q",    Q, 32'h0033_0011);
    check("direct_pend", {28'h0, PEND}, 32'h0);
    EN = '0; D = 32'hAAAA_AAAA;
    step();
    check("direct_hold_q", Q, 32'h0033_0011);

    // 3: buffered load then commit
    MODE = 1'b1; EN = 4'b0011; D = 32'h0000_BBAA;
    step();
    check("buf_q_unch", Q, 32'h0033_0011);
    check("buf_pend",   {28'h0, PEND}, 32'h3);
    check("buf_npend",  {29'h0, NPEND}, 32'h2);
    EN = '0; COMMIT = 1'b1; D = 32'h5555_5555;
    step();
    check("commit_q",     Q, 32'h0033_BBAA);
    check("commit_pend",  {28'h0, PEND}, 32'h0);
    check("commit_npend", {29'h0, NPEND}, 32'h0);
    // commit with nothing pending changes nothing
    step();
    check("commit_idle_q", Q, 32'h0033_BBAA);

    // 4: reload before commit, then write-through alongside commit
    COMMIT = 1'b0; EN = 4'b0001; D = 32'h0000_0011;
    step();
    check("reload1_npend", {29'h0, NPEND}, 32'h1);
    D = 32'h0000_0022;
    step();
    check("reload2_npend", {29'h0, NPEND}, 32'h1);
    check("reload2_pend",  {28'h0, PEND}, 32'h1);
    check("reload2_q",     Q, 32'h0033_BBAA);
    COMMIT = 1'b1; EN = 4'b0010; D = 32'h0000_3300;
    step();
    check("wt_q",     Q, 32'h0033_3322);
    check("wt_pend",  {28'h0, PEND}, 32'h0);
    check("wt_npend", {29'h0, NPEND}, 32'h0);

    // 5: reset discards a pending load
    COMMIT = 1'b0; EN = 4'b0100; D = 32'h005A_0000;
    step();
    check("pre_rst_pend", {28'h0, PEND}, 32'h4);
    check("pre_rst_q",    Q, 32'h0033_3322);
    EN = '0;
    #2 RST = 1'b1;
    #1;
    check("midrst_q",    Q, 32'h0);
    check("midrst_pend", {28'h0, PEND}, 32'h0);
    @(negedge CLK);
    RST = 1'b0; COMMIT = 1'b1;
    step();
    check("post_rst_commit_q", Q, 32'h0);

    // 6: MODE 1->0 keeps other channels pending
    COMMIT = 1'b0; EN = 4'b1000; D = 32'hC300_0000;
    step();
    check("m6_pend", {28'h0, PEND}, 32'h8);
    MODE = 1'b0; EN = 4'b0001; D = 32'h0000_0001;
    step();
    check("m6_direct_q",  Q, 32'h0000_0001);
    check("m6_pend_kept", {28'h0, PEND}, 32'h8);
    check("m6_npend",     {29'h0, NPEND}, 32'h1);
    EN = '0; COMMIT = 1'b1;
    step();
    check("m6_commit_q",     Q, 32'hC300_0001);
    check("m6_commit_npend", {29'h0, NPEND}, 32'h0);

    // all four pending at once: NPEND reaches its maximum
    COMMIT = 1'b0; MODE = 1'b1; EN = 4'hF; D = 32'h1234_5678;
    step();
    check("full_npend", {29'h0, NPEND}, 32'h4);
    check("full_q",     Q, 32'hC300_0001);
    EN = '0; COMMIT = 1'b1;
    step();
    check("full_commit_q", Q, 32'h1234_5678);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
